// File: rtl/multi_voice_sequencer.sv
// -----------------------------------------------------------------------------
// multi_voice_sequencer
//
// Purpose:
//   NUM_VOICES independent tone voices. Each voice walks its own sequence
//   memory (one period word per step), holds each note for step_div+1 PLAY
//   clocks, and synthesises a square wave whose duty is the period scaled
//   down by the per-voice volume shift. Voices run looping (music) or
//   one-shot on trigger (effects). All voice outputs are ORed into one
//   registered PWM bit for the audio jack.
//
// Ports (voice i uses slice i of every per-voice bus):
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   enable     in   [NUM_VOICES]            per-voice run/pause gate
//   loop_mode  in   [NUM_VOICES]            1 = loop forever, 0 = one-shot
//   trigger    in   [NUM_VOICES]            1-cycle pulse, restart at addr 0
//   step_div   in   [NUM_VOICES*STEP_W]     note hold = step_div+1 PLAY clocks
//   vol_shift  in   [NUM_VOICES*3]          duty = period >> (1+vol_shift)
//   seq_addr   out  [NUM_VOICES*ADDR_W]     sequence memory address
//   seq_data   in   [NUM_VOICES*PERIOD_W]   word, valid 1 cycle after seq_addr
//   busy       out  [NUM_VOICES]            voice not IDLE
//   voice_out  out  [NUM_VOICES]            per-voice square wave (registered)
//   pwm_out    out                          OR of all voices (registered)
//   audio_en   out                          audio jack enable
//
// Sequence words: 0 = rest, all-ones = end marker, otherwise period in clocks.
//
// Handshake: there is no valid/ready pair. The memory interface is a fixed
// latency read: the address is held through FETCH1 (memory samples it on the
// edge leaving FETCH1) and the word is captured in FETCH2.
// -----------------------------------------------------------------------------
module multi_voice_sequencer #(
   parameter int NUM_VOICES = 4,
   parameter int PERIOD_W   = 20,
   parameter int ADDR_W     = 9,
   parameter int STEP_W     = 23
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_VOICES-1:0]          enable,
   input  logic [NUM_VOICES-1:0]          loop_mode,
   input  logic [NUM_VOICES-1:0]          trigger,
   input  logic [NUM_VOICES*STEP_W-1:0]   step_div,
   input  logic [NUM_VOICES*3-1:0]        vol_shift,
   output logic [NUM_VOICES*ADDR_W-1:0]   seq_addr,
   input  logic [NUM_VOICES*PERIOD_W-1:0] seq_data,
   output logic [NUM_VOICES-1:0]          busy,
   output logic [NUM_VOICES-1:0]          voice_out,
   output logic                           pwm_out,
   output logic                           audio_en
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH1 = 2'd1,
      S_FETCH2 = 2'd2,
      S_PLAY   = 2'd3
   } state_e;

   localparam logic [PERIOD_W-1:0] END_MARK = '1;

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      state_e              state_q, state_d;
      logic [ADDR_W-1:0]   addr_q, addr_d;
      logic [STEP_W-1:0]   tick_q, tick_d;
      logic [PERIOD_W-1:0] phase_q, phase_d;
      logic [PERIOD_W-1:0] period_q, period_d;
      logic                vout_q, vout_d;

      logic [STEP_W-1:0]   sd;
      logic [2:0]          vs;
      logic [PERIOD_W-1:0] data;
      logic [PERIOD_W-1:0] duty;

      assign sd   = step_div[v*STEP_W +: STEP_W];
      assign vs   = vol_shift[v*3 +: 3];
      assign data = seq_data[v*PERIOD_W +: PERIOD_W];
      // Shift amount is 1..8, so it needs four bits to avoid wrapping at vs=7.
      assign duty = period_q >> ({1'b0, vs} + 4'd1);

      always_comb begin
         state_d  = state_q;
         addr_d   = addr_q;
         tick_d   = tick_q;
         phase_d  = phase_q;
         period_d = period_q;
         vout_d   = 1'b0;
         if (trigger[v]) begin
            // Trigger overrides everything, even a pause or an end-marker capture.
            state_d = S_FETCH1;
            addr_d  = '0;
            tick_d  = '0;
            phase_d = '0;
         end else if (enable[v]) begin
            // With enable low nothing below runs, so the whole voice freezes.
            case (state_q)
               S_IDLE: begin
                  if (loop_mode[v]) begin
                     state_d = S_FETCH1;
                     addr_d  = '0;
                  end
               end
               S_FETCH1: state_d = S_FETCH2;
               S_FETCH2: begin
                  if (data == END_MARK) begin
                     if (loop_mode[v]) begin
                        addr_d  = '0;
                        state_d = S_FETCH1;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else begin
                     period_d = data;
                     phase_d  = '0;
                     tick_d   = '0;
                     state_d  = S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (period_q != '0) begin
                     vout_d  = (phase_q < duty);
                     phase_d = (phase_q == period_q - 1'b1) ? '0 : phase_q + 1'b1;
                  end
                  if (tick_q == sd) begin
                     tick_d  = '0;
                     addr_d  = addr_q + 1'b1;
                     // Falling off the end of memory ends a one-shot voice.
                     state_d = (addr_q == '1 && !loop_mode[v]) ? S_IDLE : S_FETCH1;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            tick_q   <= '0;
            phase_q  <= '0;
            period_q <= '0;
            vout_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            tick_q   <= tick_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            vout_q   <= vout_d;
         end
      end

      assign seq_addr[v*ADDR_W +: ADDR_W] = addr_q;
      assign busy[v]                      = (state_q != S_IDLE);
      assign voice_out[v]                 = vout_q;
   end

   logic pwm_q;
   logic audio_en_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         pwm_q      <= 1'b0;
         audio_en_q <= 1'b0;
      end else begin
         pwm_q      <= |voice_out;
         audio_en_q <= 1'b1;
      end
   end

   assign pwm_out  = pwm_q;
   assign audio_en = audio_en_q;

endmodule

// File: tb/tb_multi_voice_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multi_voice_sequencer
//
// Bench for multi_voice_sequencer with small parameters so address wrap and
// end-of-memory behaviour are reachable quickly. A behavioural model steps
// every voice on each rising edge from the rules (fetch countdown, note hold
// count, phase modulo period, duty by division) and pushes the expected
// output snapshot into a queue; a monitor pops one entry per falling edge and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multi_voice_sequencer;

   localparam int NV    = 4;
   localparam int PW    = 12;
   localparam int AW    = 4;
   localparam int SW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int EW    = 2 + 2*NV + NV*AW;
   localparam logic [PW-1:0] ALL1 = '1;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [NV-1:0]      enable;
   logic [NV-1:0]      loop_mode;
   logic [NV-1:0]      trigger;
   logic [NV*SW-1:0]   step_div;
   logic [NV*3-1:0]    vol_shift;
   logic [NV*AW-1:0]   seq_addr;
   logic [NV*PW-1:0]   seq_data;
   logic [NV-1:0]      busy;
   logic [NV-1:0]      voice_out;
   logic               pwm_out;
   logic               audio_en;

   multi_voice_sequencer #(
      .NUM_VOICES(NV), .PERIOD_W(PW), .ADDR_W(AW), .STEP_W(SW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .loop_mode (loop_mode),
      .trigger   (trigger),
      .step_div  (step_div),
      .vol_shift (vol_shift),
      .seq_addr  (seq_addr),
      .seq_data  (seq_data),
      .busy      (busy),
      .voice_out (voice_out),
      .pwm_out   (pwm_out),
      .audio_en  (audio_en)
   );

   // ---------------- sequence memories (registered read) ----------------
   logic [PW-1:0] mem [NV][DEPTH];

   initial seq_data = '0;
   always @(posedge clock) begin
      for (int i = 0; i < NV; i++)
         seq_data[i*PW +: PW] <= mem[i][seq_addr[i*AW +: AW]];
   end

   // ---------------- reference model ----------------
   int m_active    [NV];   // voice is doing anything at all
   int m_fetch_left[NV];   // 2 = address phase, 1 = data phase, 0 = playing
   int m_addr      [NV];
   int m_hold      [NV];   // PLAY clocks already spent on the current note
   int m_phase     [NV];
   int m_period    [NV];
   int m_vout      [NV];
   int m_pwm;
   int m_audio;

   logic [EW-1:0] exp_q[$];
   int n_tests;
   int n_fail;
   int cyc;

   task automatic model_voice(input int i);
      int en, lm, tr, sd, vs, w, duty;
      en = int'(enable[i]);
      lm = int'(loop_mode[i]);
      tr = int'(trigger[i]);
      sd = int'(step_div[i*SW +: SW]);
      vs = int'(vol_shift[i*3 +: 3]);
      if (tr != 0) begin
         m_active[i] = 1; m_fetch_left[i] = 2; m_addr[i] = 0;
         m_hold[i] = 0; m_phase[i] = 0; m_vout[i] = 0;
      end else if (en == 0) begin
         m_vout[i] = 0;
      end else if (m_active[i] == 0) begin
         m_vout[i] = 0;
         if (lm != 0) begin
            m_active[i] = 1; m_fetch_left[i] = 2; m_addr[i] = 0;
         end
      end else if (m_fetch_left[i] == 2) begin
         m_vout[i] = 0;
         m_fetch_left[i] = 1;
      end else if (m_fetch_left[i] == 1) begin
         m_vout[i] = 0;
         w = int'(mem[i][m_addr[i]]);
         if (w == int'(ALL1)) begin
            if (lm != 0) begin m_addr[i] = 0; m_fetch_left[i] = 2; end
            else m_active[i] = 0;
         end else begin
            m_period[i] = w; m_phase[i] = 0; m_hold[i] = 0; m_fetch_left[i] = 0;
         end
      end else begin
         if (m_period[i] != 0) begin
            duty = m_period[i] / (1 << (1 + vs));
            m_vout[i]  = (m_phase[i] < duty) ? 1 : 0;
            m_phase[i] = (m_phase[i] + 1) % m_period[i];
         end else begin
            m_vout[i] = 0;
         end
         if (m_hold[i] == sd) begin
            m_hold[i] = 0;
            if (m_addr[i] == DEPTH-1 && lm == 0) m_active[i] = 0;
            else m_fetch_left[i] = 2;
            m_addr[i] = (m_addr[i] + 1) % DEPTH;
         end else begin
            m_hold[i] = m_hold[i] + 1;
         end
      end
   endtask

   always @(posedge clock) begin : model_blk
      int any_on;
      logic [EW-1:0] e;
      any_on = 0;
      for (int i = 0; i < NV; i++) any_on = any_on | m_vout[i];
      if (reset) begin
         for (int i = 0; i < NV; i++) begin
            m_active[i] = 0; m_fetch_left[i] = 0; m_addr[i] = 0; m_hold[i] = 0;
            m_phase[i] = 0; m_period[i] = 0; m_vout[i] = 0;
         end
         m_pwm = 0; m_audio = 0;
      end else begin
         m_pwm = any_on; m_audio = 1;
         for (int i = 0; i < NV; i++) model_voice(i);
      end
      e = '0;
      e[EW-1] = (m_audio != 0);
      e[EW-2] = (m_pwm != 0);
      for (int i = 0; i < NV; i++) begin
         e[NV*AW + NV + i] = (m_active[i] != 0);
         e[NV*AW + i]      = (m_vout[i] != 0);
         e[i*AW +: AW]     = AW'(m_addr[i]);
      end
      exp_q.push_back(e);
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin : mon_blk
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {audio_en, pwm_out, busy, voice_out, seq_addr};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got audio_en=%b pwm=%b busy=%b vout=%b addr=%h, expected audio_en=%b pwm=%b busy=%b vout=%b addr=%h",
                     cyc, a[EW-1], a[EW-2], a[NV*AW+NV +: NV], a[NV*AW +: NV], a[NV*AW-1:0],
                     e[EW-1], e[EW-2], e[NV*AW+NV +: NV], e[NV*AW +: NV], e[NV*AW-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_trigger(input int v);
      trigger[v] = 1'b1;
      @(negedge clock);
      trigger[v] = 1'b0;
   endtask

   task automatic clear_mems();
      for (int i = 0; i < NV; i++)
         for (int a = 0; a < DEPTH; a++) mem[i][a] = '0;
   endtask

   task automatic quiet_inputs();
      enable = '0; loop_mode = '0; trigger = '0; step_div = '0; vol_shift = '0;
   endtask

   task automatic set_sd(input int v, input int sd);
      step_div[v*SW +: SW] = SW'(sd);
   endtask

   task automatic set_vs(input int v, input int vs);
      vol_shift[v*3 +: 3] = 3'(vs);
   endtask

   task automatic wait_addr(input int v, input int target);
      int k;
      k = 0;
      while (int'(seq_addr[v*AW +: AW]) != target && k < 300) begin
         @(negedge clock);
         k++;
      end
      if (k >= 300) begin
         n_tests++; n_fail++;
         $display("FAIL wait_addr voice %0d: address %0d not reached within 300 cycles", v, target);
      end
   endtask

   task automatic random_word(output logic [PW-1:0] w);
      int r;
      r = $urandom_range(0, 99);
      if (r < 20)      w = '0;
      else if (r < 32) w = ALL1;
      else             w = PW'($urandom_range(2, 40));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_tests = 0; n_fail = 0; cyc = 0;
      quiet_inputs();
      reset = 1'b1;
      clear_mems();
      cycles(3);

      // Looping voice 0: {100, rest, end}, 12 clocks per step.
      mem[0][0] = PW'(100); mem[0][1] = '0; mem[0][2] = ALL1;
      loop_mode[0] = 1'b1; enable[0] = 1'b1; set_sd(0, 9);
      reset = 1'b0;
      cycles(60);

      // One-shot voice 1: {40, end}, two full periods per note.
      enable[0] = 1'b0;
      mem[1][0] = PW'(40); mem[1][1] = ALL1;
      enable[1] = 1'b1; set_sd(1, 79);
      cycles(5);
      pulse_trigger(1);
      cycles(100);
      cycles(20);
      pulse_trigger(1);
      cycles(90);

      // Volume on voice 2: period 64 with shifts 0, 2, 7.
      mem[2][0] = PW'(64); mem[2][1] = PW'(64); mem[2][2] = PW'(64); mem[2][3] = ALL1;
      enable[2] = 1'b1; set_sd(2, 63); set_vs(2, 0);
      pulse_trigger(2);
      cycles(67); set_vs(2, 2);
      cycles(66); set_vs(2, 7);
      cycles(70);

      // Pause voice 2 at phase 17 of its first note.
      set_vs(2, 0);
      pulse_trigger(2);
      cycles(2 + 17);
      enable[2] = 1'b0;
      cycles(10);
      enable[2] = 1'b1;
      cycles(80);

      // Retrigger voice 3 at address 5, then address wrap in both modes.
      for (int a = 0; a < DEPTH; a++) mem[3][a] = PW'(5);
      enable[3] = 1'b1; loop_mode[3] = 1'b1; set_sd(3, 1);
      wait_addr(3, 5);
      pulse_trigger(3);
      cycles(100);
      loop_mode[3] = 1'b0;
      pulse_trigger(3);
      cycles(80);

      // Trigger coincident with end-marker capture on one-shot voice 1.
      set_sd(1, 3);
      pulse_trigger(1);
      cycles(7);
      pulse_trigger(1);
      cycles(20);

      // Reset in mid-play, loop voice 0 refetches from address 0.
      enable[0] = 1'b1;
      cycles(17);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      cycles(40);

      // Randomised rounds.
      for (int r = 0; r < 6; r++) begin
         reset = 1'b1;
         quiet_inputs();
         for (int i = 0; i < NV; i++) begin
            for (int a = 0; a < DEPTH; a++) random_word(mem[i][a]);
            loop_mode[i] = 1'($urandom_range(0, 1));
            set_sd(i, $urandom_range(0, 5));
            set_vs(i, $urandom_range(0, 7));
         end
         cycles(2);
         reset = 1'b0;
         for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NV; i++) begin
               enable[i]  = ($urandom_range(0, 9) != 0);
               trigger[i] = ($urandom_range(0, 49) == 0);
               if ($urandom_range(0, 99) == 0) loop_mode[i] = ~loop_mode[i];
               if ($urandom_range(0, 19) == 0) set_vs(i, $urandom_range(0, 7));
            end
            if (r == 5 && c == 200) reset = 1'b1;
            else reset = 1'b0;
            @(negedge clock);
         end
      end

      quiet_inputs();
      cycles(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
